// File: rtl/hbwif_word_aligner.sv
// Bit-pair word aligner: hunts for SYNC in both bit phases, verifies LOCK_COUNT
// consecutive sync words, then emits one aligned word every WORD_W/2 cycles.
module hbwif_word_aligner #(
  parameter int                 WORD_W     = 8,
  parameter logic [WORD_W-1:0]  SYNC       = WORD_W'(8'hB5),
  parameter int                 LOCK_COUNT = 3
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [1:0]        io_rx_data,
  input  logic              io_realign,
  output logic [WORD_W-1:0] io_out_word,
  output logic              io_out_valid,
  output logic              io_out_is_sync,
  output logic              io_locked,
  output logic              io_phase,
  output logic [7:0]        io_sync_count
);

  localparam int              HALF     = WORD_W / 2;
  localparam int              CW       = (HALF > 1) ? $clog2(HALF) : 1;
  localparam logic [CW-1:0]   CYC_LAST = CW'(HALF - 1);
  localparam logic [3:0]      LOCK_N   = 4'(LOCK_COUNT);

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } state_t;

  state_t              state_r;
  logic [WORD_W-2:0]   hist_r;
  logic [WORD_W:0]     hist_next_s;
  logic [WORD_W-1:0]   win0_s;
  logic [WORD_W-1:0]   win1_s;
  logic [WORD_W-1:0]   bnd_word_s;
  logic                boundary_s;
  logic                phase_r;
  logic [CW-1:0]       cyc_r;
  logic [3:0]          match_r;
  logic [WORD_W-1:0]   out_word_r;
  logic                out_valid_r;
  logic                out_is_sync_r;
  logic                locked_r;
  logic [7:0]          sync_count_r;

  // Registered history plus the incoming pair form the WORD_W+1-bit search
  // history; [0] arrives before [1], so it lands one position nearer the MSB.
  always_comb begin
    hist_next_s = {hist_r, io_rx_data[0], io_rx_data[1]};
    win0_s      = hist_next_s[WORD_W-1:0];
    win1_s      = hist_next_s[WORD_W:1];
    boundary_s  = (cyc_r == CYC_LAST);
    if (phase_r) begin
      bnd_word_s = win1_s;
    end else begin
      bnd_word_s = win0_s;
    end
  end

  // Alignment FSM with every output registered.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_r       <= HUNT;
      hist_r        <= '0;
      phase_r       <= 1'b0;
      cyc_r         <= '0;
      match_r       <= 4'd0;
      out_word_r    <= '0;
      out_valid_r   <= 1'b0;
      out_is_sync_r <= 1'b0;
      locked_r      <= 1'b0;
      sync_count_r  <= 8'd0;
    end else begin
      hist_r        <= hist_next_s[WORD_W-2:0];
      out_valid_r   <= 1'b0;
      out_is_sync_r <= 1'b0;
      if (io_realign) begin
        state_r      <= HUNT;
        locked_r     <= 1'b0;
        match_r      <= 4'd0;
        cyc_r        <= '0;
        sync_count_r <= 8'd0;
      end else begin
        case (state_r)
          HUNT: begin
            if ((win1_s == SYNC) || (win0_s == SYNC)) begin
              phase_r <= (win1_s == SYNC);
              match_r <= 4'd1;
              cyc_r   <= '0;
              if (LOCK_N == 4'd1) begin
                state_r  <= LOCKED;
                locked_r <= 1'b1;
              end else begin
                state_r <= VERIFY;
              end
            end else begin
              match_r <= 4'd0;
            end
          end
          VERIFY: begin
            if (boundary_s) begin
              cyc_r <= '0;
              if (bnd_word_s == SYNC) begin
                match_r <= match_r + 4'd1;
                if ((match_r + 4'd1) == LOCK_N) begin
                  state_r  <= LOCKED;
                  locked_r <= 1'b1;
                end else begin
                  state_r <= VERIFY;
                end
              end else begin
                state_r      <= HUNT;
                match_r      <= 4'd0;
                sync_count_r <= 8'd0;
              end
            end else begin
              cyc_r <= cyc_r + CW'(1);
            end
          end
          LOCKED: begin
            // The lock edge is itself a boundary, so the counter just keeps running.
            if (boundary_s) begin
              cyc_r         <= '0;
              out_word_r    <= bnd_word_s;
              out_valid_r   <= 1'b1;
              out_is_sync_r <= (bnd_word_s == SYNC);
              if ((bnd_word_s == SYNC) && (sync_count_r != 8'hFF)) begin
                sync_count_r <= sync_count_r + 8'd1;
              end else begin
                sync_count_r <= sync_count_r;
              end
            end else begin
              cyc_r <= cyc_r + CW'(1);
            end
          end
          default: begin
            state_r      <= HUNT;
            locked_r     <= 1'b0;
            match_r      <= 4'd0;
            cyc_r        <= '0;
            sync_count_r <= 8'd0;
          end
        endcase
      end
    end
  end

  assign io_out_word    = out_word_r;
  assign io_out_valid   = out_valid_r;
  assign io_out_is_sync = out_is_sync_r;
  assign io_locked      = locked_r;
  assign io_phase       = phase_r;
  assign io_sync_count  = sync_count_r;

endmodule

// File: tb/tb_hbwif_word_aligner.sv
// Directed bench for hbwif_word_aligner: both lock phases, verify failure,
// realign, sync-count saturation and mid-word reset.
module tb_hbwif_word_aligner;

  logic       clock;
  logic       reset_n;
  logic [1:0] io_rx_data;
  logic       io_realign;
  logic [7:0] io_out_word;
  logic       io_out_valid;
  logic       io_out_is_sync;
  logic       io_locked;
  logic       io_phase;
  logic [7:0] io_sync_count;

  int checks = 0;
  int errors = 0;
  bit bitq[$];

  hbwif_word_aligner dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .io_rx_data     (io_rx_data),
    .io_realign     (io_realign),
    .io_out_word    (io_out_word),
    .io_out_valid   (io_out_valid),
    .io_out_is_sync (io_out_is_sync),
    .io_locked      (io_locked),
    .io_phase       (io_phase),
    .io_sync_count  (io_sync_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_word(input logic [7:0] w);
    for (int i = 7; i >= 0; i--) bitq.push_back(w[i]);
  endtask

  // One clock: earlier stream bit on [0], later on [1]; outputs sampled 1 time unit after the edge.
  task automatic tick();
    logic b0;
    logic b1;
    b0 = 1'b0;
    b1 = 1'b0;
    if (bitq.size() > 0) b0 = bitq.pop_front();
    if (bitq.size() > 0) b1 = bitq.pop_front();
    io_rx_data = {b1, b0};
    @(posedge clock);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    bitq.delete();
    ticks(2);
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n    = 1'b1;
    io_rx_data = 2'b00;
    io_realign = 1'b0;
    #3;
    reset_n = 1'b0;
    #1;
    chk("rst_word",  32'(io_out_word),    32'h0);
    chk("rst_valid", 32'(io_out_valid),   32'h0);
    chk("rst_sync",  32'(io_out_is_sync), 32'h0);
    chk("rst_lock",  32'(io_locked),      32'h0);
    chk("rst_phase", 32'(io_phase),       32'h0);
    chk("rst_cnt",   32'(io_sync_count),  32'h0);
    ticks(2);
    reset_n = 1'b1;

    // Phase 0: B5 words complete on edges 4, 8, 12; 3C on edge 16.
    push_word(8'hB5); push_word(8'hB5); push_word(8'hB5); push_word(8'h3C);
    ticks(11);
    chk("p0_lock_early", 32'(io_locked), 32'h0);
    tick();
    chk("p0_lock",       32'(io_locked),    32'h1);
    chk("p0_phase",      32'(io_phase),     32'h0);
    chk("p0_nv_lockword",32'(io_out_valid), 32'h0);
    ticks(3);
    chk("p0_nv_mid",     32'(io_out_valid), 32'h0);
    tick();
    chk("p0_valid",      32'(io_out_valid),   32'h1);
    chk("p0_word",       32'(io_out_word),    32'h3C);
    chk("p0_is_sync",    32'(io_out_is_sync), 32'h0);
    chk("p0_cnt",        32'(io_sync_count),  32'h0);
    tick();
    chk("p0_pulse_end",  32'(io_out_valid),   32'h0);
    chk("p0_word_hold",  32'(io_out_word),    32'h3C);

    // Phase 1: one leading bit, words complete on edges 5, 9, 13, 17.
    do_reset();
    bitq.push_back(1'b0);
    push_word(8'hB5); push_word(8'hB5); push_word(8'hB5); push_word(8'hB5);
    ticks(12);
    chk("p1_lock_early", 32'(io_locked), 32'h0);
    tick();
    chk("p1_lock",       32'(io_locked), 32'h1);
    chk("p1_phase",      32'(io_phase),  32'h1);
    ticks(3);
    chk("p1_nv_mid",     32'(io_out_valid), 32'h0);
    tick();
    chk("p1_valid",      32'(io_out_valid),   32'h1);
    chk("p1_word",       32'(io_out_word),    32'hB5);
    chk("p1_is_sync",    32'(io_out_is_sync), 32'h1);
    chk("p1_cnt",        32'(io_sync_count),  32'h1);

    // Verify failure on A5 at edge 12, then relock on edge 24.
    do_reset();
    push_word(8'hB5); push_word(8'hB5); push_word(8'hA5);
    push_word(8'hB5); push_word(8'hB5); push_word(8'hB5);
    ticks(12);
    chk("vf_nolock",      32'(io_locked), 32'h0);
    ticks(11);
    chk("vf_relock_early",32'(io_locked), 32'h0);
    tick();
    chk("vf_relock",      32'(io_locked), 32'h1);
    chk("vf_phase",       32'(io_phase),  32'h0);

    // Realign: one sync output at edge 28, realign on edge 29, relock at edge 40.
    push_word(8'hB5); push_word(8'hB5); push_word(8'hB5); push_word(8'hB5);
    ticks(4);
    chk("ra_valid",  32'(io_out_valid),  32'h1);
    chk("ra_cnt1",   32'(io_sync_count), 32'h1);
    io_realign = 1'b1;
    tick();
    io_realign = 1'b0;
    chk("ra_unlock", 32'(io_locked),     32'h0);
    chk("ra_cnt0",   32'(io_sync_count), 32'h0);
    chk("ra_nv",     32'(io_out_valid),  32'h0);
    ticks(10);
    chk("ra_relock_early", 32'(io_locked), 32'h0);
    tick();
    chk("ra_relock", 32'(io_locked), 32'h1);

    // Saturation: 300 sync words while locked.
    for (int i = 0; i < 300; i++) push_word(8'hB5);
    ticks(1200);
    chk("sat_valid", 32'(io_out_valid),  32'h1);
    chk("sat_cnt",   32'(io_sync_count), 32'hFF);
    push_word(8'hB5);
    ticks(2);
    chk("sat_locked", 32'(io_locked), 32'h1);
    reset_n = 1'b0;
    #1;
    chk("mr_word",  32'(io_out_word),    32'h0);
    chk("mr_valid", 32'(io_out_valid),   32'h0);
    chk("mr_sync",  32'(io_out_is_sync), 32'h0);
    chk("mr_lock",  32'(io_locked),      32'h0);
    chk("mr_phase", 32'(io_phase),       32'h0);
    chk("mr_cnt",   32'(io_sync_count),  32'h0);
    bitq.delete();
    ticks(2);
    reset_n = 1'b1;
    ticks(4);
    chk("mr_after_valid", 32'(io_out_valid), 32'h0);
    chk("mr_after_lock",  32'(io_locked),    32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
